regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between the ALU-stage and ID-stage writeback sources.
//  Each source has a 1-entry holding slot and a valid/ready handshake.
//  Contested cycles are arbitrated round-robin, with write ordering preserved when both slots target
//  the same register. Outputs drive the register file's write port (addr/enable/select/data) from
//  registers, and report pending writes as read hazards to decode.
// PARAMETERS
//  DATA_W  32  width of write data
//  ADDR_W  3   register address width; NREG = 2**ADDR_W (8)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  alu_req      in   1       ALU write request
//  alu_addr     in   ADDR_W  ALU destination register
//  alu_data     in   DATA_W  ALU write data
//  alu_ready    out  1       ALU slot can accept this cycle
//  id_req       in   1       ID write request
//  id_addr      in   ADDR_W  ID destination register
//  id_data      in   DATA_W  ID write data
//  id_ready     out  1       ID slot can accept this cycle
//  rf_w_addr    out  ADDR_W  to register-file write address
//  rf_w_enable  out  1       to register-file write enable
//  rf_w_select  out  1       to register-file mux select: 0=ALU, 1=ID
//  rf_w_alu     out  DATA_W  to register-file ALU data lane
//  rf_w_id      out  DATA_W  to register-file ID data lane
//  chk_addr_0   in   ADDR_W  decode read-port-0 address to check
//  chk_addr_1   in   ADDR_W  decode read-port-1 address to check
//  hazard_0     out  1       chk_addr_0 has a pending or in-flight write
//  hazard_1     out  1       chk_addr_1 has a pending or in-flight write
//  pending      out  NREG    busy bit per register
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - Both slots invalid; all rf_w_* = 0; pending = 0; hazard_* = 0.
//   - RR pointer = ALU-next; age bit cleared.
//   - alu_ready/id_ready forced 0 while rst_n low.
//   - Reset mid-operation discards held writes and drops rf_w_enable immediately.
//  Accept
//   - Slot X loads {addr,data} at the edge where X_req && X_ready.
//   - X_ready = !slotX_v || grantX (a slot may drain and refill in the same cycle).
//   - X_ready must not depend combinationally on X_req.
//  Grant (combinational, from slot state only)
//   - One slot valid: grant it.
//   - Both valid, addresses differ: round-robin. Grant the source not granted last; pointer updates
//     only on contested grants.
//   - Both valid, same address: grant the older entry (age bit set when one slot is loaded while the
//     other already holds). If both were accepted in the same cycle, ALU goes first, so the ID value
//     lands last.
//   - A granted slot clears at the edge unless it is refilled at that same edge.
//  Output stage (registered)
//   - rf_w_enable <= any grant; rf_w_select <= grantID; rf_w_addr <= granted addr.
//   - The granted data goes on its own lane; the unselected lane is 0. With no grant, all rf_w_* <= 0.
//   - Latency: request accepted at edge E -> rf_w_enable high in the cycle after E+1 -> the register
//     file commits at edge E+2.
//   - Uncontested throughput: 1 write/cycle per source.
//   - Contested: combined 1 write/cycle; the losing source sees ready=0 for that cycle.
//  Hazard / pending
//   - pending[r] = (slotALU_v && addr==r) | (slotID_v && addr==r) | (rf_w_enable && rf_w_addr==r).
//   - hazard_k = pending[chk_addr_k], combinational.
//   - Writes to any register (including r0) are treated identically.
// TESTING
//  1 Reset: rst_n=0 with alu_req=1 -> rf_w_enable=0, pending=8'h00, alu_ready=0.
//    Release -> first write accepted next edge.
//  2 Single write: alu_req addr=3 data=32'hDEAD_BEEF -> two edges later rf_w_enable=1, select=0,
//    rf_w_alu=DEADBEEF, rf_w_id=0. pending[3]=1 from acceptance through the commit cycle.
//  3 Contention: both req every cycle, addr ALU=1 / ID=2 -> grants alternate ALU,ID,ALU,...
//    Each source ready=0 on alternate cycles; no write lost or duplicated.
//  4 Same-address tie: ALU(5,32'h11) and ID(5,32'h22) accepted in the same cycle -> ALU write first,
//    then ID. Register 5 ends with 32'h22.
//  5 Ordering: ID(4,32'hAA) accepted, ALU(4,32'hBB) accepted next cycle while ID still held ->
//    ID written before ALU. Final value 32'hBB.
//  6 Hazard/reset: slot holds addr 6, chk_addr_0=6 -> hazard_0=1. Assert rst_n=0 mid-flight ->
//    hazard_0=0 and rf_w_enable=0 immediately, with no write afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the two writeback request channels, the register-file write
//   port and the decode hazard-check port of regfile_write_arbiter.
//   slave  : arbiter side (takes requests, drives write port and hazards)
//   master : environment side (issues requests, checks hazards)
// Signals
//   alu_req/alu_addr/alu_data/alu_ready  ALU-stage write channel
//   id_req/id_addr/id_data/id_ready      ID-stage write channel
//   rf_w_addr/enable/select/alu/id       register-file write port
//   chk_addr_0/1, hazard_0/1             decode read-address hazard check
//   pending                              busy bit per register
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  localparam int NREG = 1 << ADDR_W;

  logic              alu_req;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              id_req;
  logic [ADDR_W-1:0] id_addr;
  logic [DATA_W-1:0] id_data;
  logic              id_ready;

  logic [ADDR_W-1:0] rf_w_addr;
  logic              rf_w_enable;
  logic              rf_w_select;
  logic [DATA_W-1:0] rf_w_alu;
  logic [DATA_W-1:0] rf_w_id;

  logic [ADDR_W-1:0] chk_addr_0;
  logic [ADDR_W-1:0] chk_addr_1;
  logic              hazard_0;
  logic              hazard_1;
  logic [NREG-1:0]   pending;

  modport slave (
    input  alu_req, alu_addr, alu_data,
    output alu_ready,
    input  id_req, id_addr, id_data,
    output id_ready,
    output rf_w_addr, rf_w_enable, rf_w_select, rf_w_alu, rf_w_id,
    input  chk_addr_0, chk_addr_1,
    output hazard_0, hazard_1, pending
  );

  modport master (
    output alu_req, alu_addr, alu_data,
    input  alu_ready,
    output id_req, id_addr, id_data,
    input  id_ready,
    input  rf_w_addr, rf_w_enable, rf_w_select, rf_w_alu, rf_w_id,
    output chk_addr_0, chk_addr_1,
    input  hazard_0, hazard_1, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the ALU-stage and
//   ID-stage writeback sources. Each source owns a one-entry holding slot.
//   Contested cycles are granted round-robin, except when both slots target
//   the same register, where the older entry goes first so the later value
//   lands last. The write port is driven from registers; pending writes
//   (held in a slot or on the write port) are reported to decode as hazards.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_arbiter_if.slave (request channels, write port,
//          hazard check)
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  // holding slots
  logic              alu_v;
  logic [ADDR_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_d;
  logic              id_v;
  logic [ADDR_W-1:0] id_a;
  logic [DATA_W-1:0] id_d;

  // rr_id_next: ID wins the next contested different-address cycle.
  // age_id_older: with both slots valid, the ID entry arrived first.
  logic rr_id_next;
  logic age_id_older;

  logic grant_alu;
  logic grant_id;
  logic alu_load;
  logic id_load;

  logic [NREG-1:0] pend;

  // Grant is a function of slot state only, so ready never depends on req.
  always_comb begin
    grant_alu = 1'b0;
    grant_id  = 1'b0;
    if (alu_v && id_v) begin
      if (alu_a == id_a) begin
        if (age_id_older) grant_id  = 1'b1;
        else              grant_alu = 1'b1;
      end else begin
        if (rr_id_next)   grant_id  = 1'b1;
        else              grant_alu = 1'b1;
      end
    end else if (alu_v) begin
      grant_alu = 1'b1;
    end else if (id_v) begin
      grant_id = 1'b1;
    end
  end

  // A slot being drained this cycle can take a new entry at the same edge.
  assign bus.alu_ready = rst_n & (~alu_v | grant_alu);
  assign bus.id_ready  = rst_n & (~id_v  | grant_id);

  assign alu_load = bus.alu_req & bus.alu_ready;
  assign id_load  = bus.id_req  & bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_v <= 1'b0;
      alu_a <= '0;
      alu_d <= '0;
    end else if (alu_load) begin
      alu_v <= 1'b1;
      alu_a <= bus.alu_addr;
      alu_d <= bus.alu_data;
    end else if (grant_alu) begin
      alu_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_v <= 1'b0;
      id_a <= '0;
      id_d <= '0;
    end else if (id_load) begin
      id_v <= 1'b1;
      id_a <= bus.id_addr;
      id_d <= bus.id_data;
    end else if (grant_id) begin
      id_v <= 1'b0;
    end
  end

  // Age only matters once both slots hold entries. A simultaneous load puts
  // ALU first; a load next to a still-held entry makes the held one older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_id_older <= 1'b0;
    end else if (alu_load && id_load) begin
      age_id_older <= 1'b0;
    end else if (alu_load && id_v && !grant_id) begin
      age_id_older <= 1'b1;
    end else if (id_load && alu_v && !grant_alu) begin
      age_id_older <= 1'b0;
    end
  end

  // Pointer moves on every contested grant, same-address ones included,
  // so the source that just lost is favoured next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_id_next <= 1'b0;
    end else if (alu_v && id_v) begin
      rr_id_next <= grant_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_w_enable <= 1'b0;
      bus.rf_w_select <= 1'b0;
      bus.rf_w_addr   <= '0;
      bus.rf_w_alu    <= '0;
      bus.rf_w_id     <= '0;
    end else begin
      bus.rf_w_enable <= grant_alu | grant_id;
      bus.rf_w_select <= grant_id;
      bus.rf_w_addr   <= grant_id ? id_a : (grant_alu ? alu_a : '0);
      bus.rf_w_alu    <= grant_alu ? alu_d : '0;
      bus.rf_w_id     <= grant_id ? id_d : '0;
    end
  end

  always_comb begin
    pend = '0;
    for (int r = 0; r < NREG; r++) begin
      pend[r] = (alu_v && (alu_a == ADDR_W'(r))) ||
                (id_v && (id_a == ADDR_W'(r))) ||
                (bus.rf_w_enable && (bus.rf_w_addr == ADDR_W'(r)));
    end
  end

  assign bus.pending  = pend;
  assign bus.hazard_0 = pend[bus.chk_addr_0];
  assign bus.hazard_1 = pend[bus.chk_addr_1];

  grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant_alu && grant_id));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two entries stamped with an arrival sequence number,
  // plus the identity of the last contested winner.
  logic              m_v    [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_data [2];
  int                m_seq  [2];
  int                m_tick;
  int                m_last;
  logic              m_en;
  logic              m_sel;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_lane [2];

  logic [DATA_W-1:0] rf_seen [NREG];

  function automatic int m_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return (m_last == 0) ? 1 : 0;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(int k);
    return rst_n && (!m_v[k] || (m_grant() == k));
  endfunction

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p;
    p = '0;
    for (int r = 0; r < NREG; r++) begin
      if (m_v[0] && int'(m_addr[0]) == r) p[r] = 1'b1;
      if (m_v[1] && int'(m_addr[1]) == r) p[r] = 1'b1;
      if (m_en && int'(m_waddr) == r)     p[r] = 1'b1;
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int   g;
    logic gi;
    logic l0;
    logic l1;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_v[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_seq[k] = 0; m_lane[k] = '0;
      end
      m_tick = 0; m_last = 1; m_en = 1'b0; m_sel = 1'b0; m_waddr = '0;
    end else begin
      g  = m_grant();
      gi = (g == 1);
      l0 = bus.alu_req && m_ready(0);
      l1 = bus.id_req && m_ready(1);
      m_en      = (g >= 0);
      m_sel     = gi;
      m_waddr   = (g >= 0) ? m_addr[gi] : '0;
      m_lane[0] = (g == 0) ? m_data[0] : '0;
      m_lane[1] = (g == 1) ? m_data[1] : '0;
      if (m_v[0] && m_v[1]) m_last = g;
      if (g >= 0) m_v[gi] = 1'b0;
      m_tick++;
      if (l0) begin
        m_v[0] = 1'b1; m_addr[0] = bus.alu_addr; m_data[0] = bus.alu_data; m_seq[0] = 2 * m_tick;
      end
      if (l1) begin
        m_v[1] = 1'b1; m_addr[1] = bus.id_addr; m_data[1] = bus.id_data; m_seq[1] = 2 * m_tick + 1;
      end
    end
  end

  // What the register file would hold, built from the DUT's write port.
  always @(posedge clk) begin
    if (rst_n && bus.rf_w_enable)
      rf_seen[bus.rf_w_addr] <= bus.rf_w_select ? bus.rf_w_id : bus.rf_w_alu;
  end

  task automatic set_in(input logic ar, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic ir, input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] idd);
    bus.alu_req = ar; bus.alu_addr = aa; bus.alu_data = ad;
    bus.id_req  = ir; bus.id_addr  = ia; bus.id_data  = idd;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.chk_addr_0 = 3'd3; bus.chk_addr_1 = 3'd7;
    set_in(1'b1, 3'd3, 32'h1, 1'b0, '0, '0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.rf_w_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en actual=%b expected=0", bus.rf_w_enable); end
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending actual=%h expected=00", bus.pending); end
    n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready actual=%b expected=0", bus.alu_ready); end
    n_checks++; if (bus.hazard_0 !== 1'b0) begin n_fail++; $display("FAIL reset_hazard0 actual=%b expected=0", bus.hazard_0); end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 3'd7, 32'h77, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready actual=%b expected=1", bus.alu_ready); end
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.pending !== 8'h80) begin n_fail++; $display("FAIL release_accept pending actual=%h expected=80", bus.pending); end
    n_checks++; if (bus.hazard_1 !== 1'b1) begin n_fail++; $display("FAIL release_hazard1 actual=%b expected=1", bus.hazard_1); end
    idle(4);
  endtask

  task automatic test_single_write();
    set_in(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.pending[3] !== 1'b1 || bus.rf_w_enable !== 1'b0) begin
      n_fail++; $display("FAIL single_held pending=%h en=%b expected pending[3]=1 en=0", bus.pending, bus.rf_w_enable); end
    @(negedge clk); #1;
    n_checks++; if ({bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr} !== {1'b1, 1'b0, 3'd3}) begin
      n_fail++; $display("FAIL single_port en/sel/addr actual=%b/%b/%0d expected=1/0/3", bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr); end
    n_checks++; if (bus.rf_w_alu !== 32'hDEAD_BEEF || bus.rf_w_id !== 32'h0) begin
      n_fail++; $display("FAIL single_lanes actual=%h/%h expected=deadbeef/00000000", bus.rf_w_alu, bus.rf_w_id); end
    n_checks++; if (bus.pending !== 8'h08) begin n_fail++; $display("FAIL single_commit_pending actual=%h expected=08", bus.pending); end
    @(negedge clk); #1;
    n_checks++; if (bus.rf_w_enable !== 1'b0 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL single_done en=%b pending=%h expected 0/00", bus.rf_w_enable, bus.pending); end
    n_checks++; if (rf_seen[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_commit actual=%h expected=deadbeef", rf_seen[3]); end
    idle(2);
  endtask

  task automatic test_contention();
    int prev_sel = -1;
    int accepts = 0;
    int writes = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 3'd1, $urandom, 1'b1, 3'd2, $urandom);
      #1;
      if (bus.rf_w_enable) begin
        writes++;
        if (prev_sel >= 0) begin
          n_checks++; if (int'(bus.rf_w_select) == prev_sel) begin
            n_fail++; $display("FAIL contention_alternate cycle=%0d sel=%b repeated", i, bus.rf_w_select); end
        end
        prev_sel = int'(bus.rf_w_select);
      end
      n_checks++; if (bus.alu_ready !== m_ready(0) || bus.id_ready !== m_ready(1)) begin
        n_fail++; $display("FAIL contention_ready cycle=%0d actual=%b%b expected=%b%b", i, bus.alu_ready, bus.id_ready, m_ready(0), m_ready(1)); end
      if (i >= 1) begin
        n_checks++; if (bus.alu_ready === bus.id_ready) begin
          n_fail++; $display("FAIL contention_one_ready cycle=%0d actual=%b%b expected one-hot", i, bus.alu_ready, bus.id_ready); end
      end
      n_checks++; if (bus.rf_w_alu !== m_lane[0] || bus.rf_w_id !== m_lane[1]) begin
        n_fail++; $display("FAIL contention_data cycle=%0d actual=%h/%h expected=%h/%h", i, bus.rf_w_alu, bus.rf_w_id, m_lane[0], m_lane[1]); end
      accepts += int'(m_ready(0)) + int'(m_ready(1));
      @(negedge clk);
    end
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rf_w_enable) writes++;
      @(negedge clk);
    end
    n_checks++; if (writes !== accepts) begin n_fail++; $display("FAIL contention_count writes=%0d expected=%0d", writes, accepts); end
  endtask

  task automatic test_same_addr_tie();
    bus.chk_addr_0 = 3'd5;
    set_in(1'b1, 3'd5, 32'h11, 1'b1, 3'd5, 32'h22);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.hazard_0 !== 1'b1) begin n_fail++; $display("FAIL tie_hazard actual=%b expected=1", bus.hazard_0); end
    @(negedge clk); #1;
    n_checks++; if ({bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr, bus.rf_w_alu} !== {1'b1, 1'b0, 3'd5, 32'h11}) begin
      n_fail++; $display("FAIL tie_first en/sel/addr/alu actual=%b/%b/%0d/%h expected=1/0/5/00000011", bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr, bus.rf_w_alu); end
    @(negedge clk); #1;
    n_checks++; if ({bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr, bus.rf_w_id} !== {1'b1, 1'b1, 3'd5, 32'h22}) begin
      n_fail++; $display("FAIL tie_second en/sel/addr/id actual=%b/%b/%0d/%h expected=1/1/5/00000022", bus.rf_w_enable, bus.rf_w_select, bus.rf_w_addr, bus.rf_w_id); end
    @(negedge clk); #1;
    n_checks++; if (rf_seen[5] !== 32'h22) begin n_fail++; $display("FAIL tie_final actual=%h expected=00000022", rf_seen[5]); end
    idle(2);
  endtask

  task automatic test_ordering();
    set_in(1'b0, '0, '0, 1'b1, 3'd4, 32'hAA);
    @(negedge clk);
    set_in(1'b1, 3'd4, 32'hBB, 1'b0, '0, '0);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_checks++; if ({bus.rf_w_enable, bus.rf_w_select, bus.rf_w_id} !== {1'b1, 1'b1, 32'hAA}) begin
      n_fail++; $display("FAIL order_first en/sel/id actual=%b/%b/%h expected=1/1/000000aa", bus.rf_w_enable, bus.rf_w_select, bus.rf_w_id); end
    @(negedge clk); #1;
    n_checks++; if ({bus.rf_w_enable, bus.rf_w_select, bus.rf_w_alu} !== {1'b1, 1'b0, 32'hBB}) begin
      n_fail++; $display("FAIL order_second en/sel/alu actual=%b/%b/%h expected=1/0/000000bb", bus.rf_w_enable, bus.rf_w_select, bus.rf_w_alu); end
    @(negedge clk); #1;
    n_checks++; if (rf_seen[4] !== 32'hBB) begin n_fail++; $display("FAIL order_final actual=%h expected=000000bb", rf_seen[4]); end
    idle(2);
  endtask

  task automatic test_hazard_reset();
    bus.chk_addr_0 = 3'd6; bus.chk_addr_1 = 3'd2;
    set_in(1'b1, 3'd6, $urandom, 1'b1, 3'd6, $urandom);
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_checks++; if (bus.hazard_0 !== 1'b1 || bus.hazard_1 !== 1'b0 || bus.pending !== 8'h40) begin
      n_fail++; $display("FAIL hazard_held h0=%b h1=%b pending=%h expected 1/0/40", bus.hazard_0, bus.hazard_1, bus.pending); end
    @(negedge clk); #1;
    n_checks++; if (bus.rf_w_enable !== 1'b1 || bus.hazard_0 !== 1'b1) begin
      n_fail++; $display("FAIL hazard_inflight en=%b h0=%b expected 1/1", bus.rf_w_enable, bus.hazard_0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.rf_w_enable !== 1'b0 || bus.hazard_0 !== 1'b0 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL hazard_reset en=%b h0=%b pending=%h expected 0/0/00", bus.rf_w_enable, bus.hazard_0, bus.pending); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.rf_w_enable !== 1'b0 || bus.pending !== 8'h00) begin
        n_fail++; $display("FAIL hazard_after_reset cycle=%0d en=%b pending=%h expected 0/00", i, bus.rf_w_enable, bus.pending); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ia;
    logic [NREG-1:0]   mp;
    for (int i = 0; i < 500; i++) begin
      aa = 3'($urandom_range(0, 7));
      ia = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin aa[2] = 1'b0; ia[2] = 1'b0; end
      set_in(1'($urandom_range(0, 9) < 7), aa, $urandom, 1'($urandom_range(0, 9) < 7), ia, $urandom);
      bus.chk_addr_0 = 3'($urandom_range(0, 7));
      bus.chk_addr_1 = 3'($urandom_range(0, 7));
      #1;
      mp = m_pending();
      n_checks++; if (bus.alu_ready !== m_ready(0)) begin n_fail++; $display("FAIL rand_alu_ready cycle=%0d actual=%b expected=%b", i, bus.alu_ready, m_ready(0)); end
      n_checks++; if (bus.id_ready !== m_ready(1)) begin n_fail++; $display("FAIL rand_id_ready cycle=%0d actual=%b expected=%b", i, bus.id_ready, m_ready(1)); end
      n_checks++; if (bus.rf_w_enable !== m_en) begin n_fail++; $display("FAIL rand_en cycle=%0d actual=%b expected=%b", i, bus.rf_w_enable, m_en); end
      n_checks++; if (bus.rf_w_select !== m_sel) begin n_fail++; $display("FAIL rand_sel cycle=%0d actual=%b expected=%b", i, bus.rf_w_select, m_sel); end
      n_checks++; if (bus.rf_w_addr !== m_waddr) begin n_fail++; $display("FAIL rand_addr cycle=%0d actual=%0d expected=%0d", i, bus.rf_w_addr, m_waddr); end
      n_checks++; if (bus.rf_w_alu !== m_lane[0]) begin n_fail++; $display("FAIL rand_alu_lane cycle=%0d actual=%h expected=%h", i, bus.rf_w_alu, m_lane[0]); end
      n_checks++; if (bus.rf_w_id !== m_lane[1]) begin n_fail++; $display("FAIL rand_id_lane cycle=%0d actual=%h expected=%h", i, bus.rf_w_id, m_lane[1]); end
      n_checks++; if (bus.pending !== mp) begin n_fail++; $display("FAIL rand_pending cycle=%0d actual=%h expected=%h", i, bus.pending, mp); end
      n_checks++; if (bus.hazard_0 !== mp[bus.chk_addr_0]) begin n_fail++; $display("FAIL rand_hazard0 cycle=%0d actual=%b expected=%b", i, bus.hazard_0, mp[bus.chk_addr_0]); end
      n_checks++; if (bus.hazard_1 !== mp[bus.chk_addr_1]) begin n_fail++; $display("FAIL rand_hazard1 cycle=%0d actual=%b expected=%b", i, bus.hazard_1, mp[bus.chk_addr_1]); end
      @(negedge clk);
    end
    idle(4);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog_timeout checks=%0d", n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < NREG; r++) rf_seen[r] = '0;
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    bus.chk_addr_0 = '0;
    bus.chk_addr_1 = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr_tie();
    test_ordering();
    test_hazard_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
